demux1_5_sched: RTL and testbench

// - Write-side counterpart of the cache 5:1 read mux: steers one N-bit word from a

---
 rtl/cache_pkg.sv | 11 +
 rtl/lane_onehot_dec.sv | 18 +
 rtl/demux1_5_sched.sv | 97 +++++++++
 tb/tb_demux1_5_sched.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared cache lane definitions: lane count, select width and demux state encoding.
package cache_pkg;

  localparam int NUM_LANES = 5;
  localparam int SEL_W     = 3;

  typedef logic [SEL_W-1:0] lane_sel_t;

  typedef enum logic {EMPTY, FULL} demux_state_t;

endpackage

// File: rtl/lane_onehot_dec.sv
// Combinational lane select -> one-hot decoder with illegal flag; zero latency, no flow control.
module lane_onehot_dec
  import cache_pkg::*;
(
  input  lane_sel_t              i_sel,
  output logic [NUM_LANES-1:0]   o_onehot,
  output logic                   o_illegal
);

  always_comb begin
    o_onehot = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      o_onehot[k] = (i_sel == lane_sel_t'(k));
    end
    o_illegal = ~|o_onehot;
  end

endmodule

// File: rtl/demux1_5_sched.sv
// 1:5 write demux with one-entry registered output stage; latency 1, full throughput.
// Backpressure from the selected lane only; illegal selects always drain. Option: DEMUX1_5_DROPCNT_EN.
module demux1_5_sched
  import cache_pkg::*;
#(
  parameter int N = 16
`ifdef DEMUX1_5_DROPCNT_EN
  ,
  parameter int CNT_W = 8
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_data,
  input  lane_sel_t            in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [N-1:0]         out_data,
  output logic [NUM_LANES-1:0] out_valid,
  input  logic [NUM_LANES-1:0] out_ready,
  output logic                 err_drop
`ifdef DEMUX1_5_DROPCNT_EN
  ,
  output logic [CNT_W-1:0]     drop_cnt
`endif
);

  demux_state_t         r_state;
  demux_state_t         w_state_nxt;
  logic [N-1:0]         r_out_data;
  logic [NUM_LANES-1:0] r_out_valid;
  logic                 r_err_drop;
  logic [NUM_LANES-1:0] w_onehot;
  logic                 w_illegal;
  logic                 w_lane_fire;
  logic                 w_in_ready;
  logic                 w_legal_acc;
  logic                 w_illegal_acc;

  lane_onehot_dec u_dec (
    .i_sel     (in_sel),
    .o_onehot  (w_onehot),
    .o_illegal (w_illegal)
  );

  assign w_lane_fire   = |(r_out_valid & out_ready);
  // Illegal words bypass the register, so they never wait on a lane.
  assign w_in_ready    = (r_state == EMPTY) || w_illegal || w_lane_fire;
  assign w_legal_acc   = in_valid && w_in_ready && !w_illegal;
  assign w_illegal_acc = in_valid && w_illegal;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: if (w_legal_acc) w_state_nxt = FULL;
      FULL:  if (w_lane_fire && !w_legal_acc) w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_out_valid <= '0;
      r_out_data  <= '0;
      r_err_drop  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_err_drop <= w_illegal_acc;
      if (w_legal_acc) begin
        r_out_data  <= in_data;
        r_out_valid <= w_onehot;
      end else if (w_lane_fire) begin
        r_out_valid <= '0;
      end
    end
  end

`ifdef DEMUX1_5_DROPCNT_EN
  logic [CNT_W-1:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_illegal_acc && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

  assign in_ready  = w_in_ready;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign err_drop  = r_err_drop;

endmodule

// File: tb/tb_demux1_5_sched.sv
// Bench for demux1_5_sched: directed steps then random traffic against a one-slot buffer model.
module tb_demux1_5_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic [2:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic [4:0]  out_valid;
  logic [4:0]  out_ready;
  logic        err_drop;
`ifdef DEMUX1_5_DROPCNT_EN
  logic [7:0]  drop_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference: a single slot that either holds (lane, word) or is empty.
  bit          m_full = 1'b0;
  int          m_lane = 0;
  logic [15:0] m_data = '0;
  bit          m_err  = 1'b0;
  int          m_cnt  = 0;

  always #5 clk = ~clk;

  demux1_5_sched dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_drop  (err_drop)
`ifdef DEMUX1_5_DROPCNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit model_ready();
    if (!m_full) return 1'b1;
    if (int'(in_sel) >= 5) return 1'b1;
    return out_ready[m_lane];
  endfunction

  // Check every output at the falling edge, then advance the model on the rising edge.
  task automatic tick();
    logic [4:0] e_vld;
    bit         e_rdy;
    bit         acc;
    @(negedge clk);
    e_vld = m_full ? 5'(1 << m_lane) : 5'b0;
    e_rdy = model_ready();
    chk("out_valid", 32'(out_valid), 32'(e_vld));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("err_drop", 32'(err_drop), 32'(m_err));
    chk("in_ready", 32'(in_ready), 32'(e_rdy));
`ifdef DEMUX1_5_DROPCNT_EN
    chk("drop_cnt", 32'(drop_cnt), 32'(m_cnt));
`endif
    @(posedge clk);
    if (rst) begin
      m_full = 1'b0;
      m_data = '0;
      m_err  = 1'b0;
      m_cnt  = 0;
    end else begin
      acc   = in_valid && e_rdy;
      m_err = acc && (int'(in_sel) >= 5);
      if (m_err && m_cnt < 255) m_cnt++;
      if (acc && int'(in_sel) < 5) begin
        m_full = 1'b1;
        m_lane = int'(in_sel);
        m_data = in_data;
      end else if (m_full && out_ready[m_lane]) begin
        m_full = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    logic [15:0] held;
    rst       = 1'b1;
    in_data   = '0;
    in_sel    = '0;
    in_valid  = 1'b0;
    out_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_err_drop", 32'(err_drop), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    rst = 1'b0;

    // Single write to lane 2
    in_data = 16'hA5A5; in_sel = 3'd2; in_valid = 1'b1; out_ready = 5'b00100;
    tick();
    in_valid = 1'b0;
    chk("single_vld", 32'(out_valid), 32'h04);
    chk("single_dat", 32'(out_data), 32'hA5A5);
    tick();
    chk("single_drain", 32'(out_valid), 32'h0);

    // Back-to-back across all lanes with every lane ready
    out_ready = 5'b11111;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_sel  = 3'(i);
      in_data = 16'($urandom);
      chk("b2b_in_ready", 32'(in_ready), 32'h1);
      tick();
      chk("b2b_walk", 32'(out_valid), 32'(1 << i));
    end
    in_valid = 1'b0;
    tick();

    // Stall on lane 3; unrelated lanes ready must not release it
    out_ready = 5'b10111;
    in_sel = 3'd3; in_data = 16'h3C3C; in_valid = 1'b1;
    tick();
    held = out_data;
    in_sel = 3'd1; in_data = 16'h1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_vld", 32'(out_valid), 32'h08);
      chk("stall_dat", 32'(out_data), 32'(held));
      chk("stall_rdy", 32'(in_ready), 32'h0);
    end
    out_ready = 5'b01000;
    #1;
    chk("release_rdy", 32'(in_ready), 32'h1);
    tick();
    chk("release_vld", 32'(out_valid), 32'h02);
    chk("release_dat", 32'(out_data), 32'h1111);

    // Illegal select while full and stalled
    out_ready = 5'b00000;
    in_sel = 3'd6; in_data = 16'hDEAD;
    #1;
    chk("illegal_rdy", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    chk("illegal_err", 32'(err_drop), 32'h1);
    chk("illegal_vld", 32'(out_valid), 32'h02);
    chk("illegal_dat", 32'(out_data), 32'h1111);
    tick();
    chk("illegal_pulse", 32'(err_drop), 32'h0);

`ifdef DEMUX1_5_DROPCNT_EN
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_sel = 3'($urandom_range(5, 7));
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("drop_sat", 32'(drop_cnt), 32'd255);
`endif

    // Reset while full: the held word is discarded
    chk("pre_rst_full", 32'(out_valid), 32'h02);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_vld", 32'(out_valid), 32'h0);
    out_ready = 5'b11111;
    tick();
    chk("mid_rst_idle", 32'(out_valid), 32'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sel    = 3'($urandom_range(0, 7));
      in_data   = 16'($urandom);
      out_ready = 5'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
